fifo_write_arbiter: RTL and testbench

- Round-robin arbiter that shares the single write port of one fifo instance between NUM_REQ producers.
- Grants one requester at a time for a burst that ends on the requester's last flag or after MAX_BURST beats.
- Muxes the granted requester's valid/data onto the fifo write port and returns the fifo's ready to that requester only.
- Sits between the accelerator's producer engines and a shared fifo; exposes the current grant ID for debug and tagging.

---
 rtl/fifo_arb_pkg.sv | 13 +
 rtl/rr_priority_pick.sv | 33 +++
 rtl/fifo_write_arbiter.sv | 110 +++++++++++
 tb/tb_fifo_write_arbiter.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_arb_pkg.sv
// Shared definitions for the fifo write-port arbiter: state encoding and
// a width helper that never returns zero.
package fifo_arb_pkg;

  localparam logic [0:0] ARB_IDLE  = 1'b0;
  localparam logic [0:0] ARB_BURST = 1'b1;

  // ceil(log2(value)) clamped to at least 1 so single-entry counters still get a bit
  function automatic int clog2_min1(input int value);
    return ($clog2(value) < 1) ? 1 : $clog2(value);
  endfunction

endpackage

// File: rtl/rr_priority_pick.sv
// Round-robin priority pick: finds the first set request bit searching
// upward from rrPtr, wrapping from NUM_REQ-1 back to 0.
module rr_priority_pick #(
  parameter int NUM_REQ  = 4,
  parameter int ID_WIDTH = 2
) (
  input  logic [NUM_REQ-1:0]  requests,
  input  logic [ID_WIDTH-1:0] rrPtr,
  output logic [ID_WIDTH-1:0] winner,
  output logic                anyReq
);

  // Walk offsets from farthest to nearest so the nearest set bit overwrites last
  always_comb begin
    int ptrInt;
    int cand;
    winner = '0;
    anyReq = 1'b0;
    ptrInt = int'(rrPtr);
    cand   = 0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      cand = ptrInt + k;
      if (cand >= NUM_REQ) cand = cand - NUM_REQ;
      for (int i = 0; i < NUM_REQ; i++) begin
        if (requests[i] && (i == cand)) begin
          winner = ID_WIDTH'(i);
          anyReq = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/fifo_write_arbiter.sv
// Shares one fifo write port between NUM_REQ producers. A requester holds
// the grant for a burst that ends on its last flag or after MAX_BURST beats;
// there is always one idle (arbitration) cycle between bursts.
//
// Handshake: a beat transfers on a rising edge where valid and ready are both
// high. wrValidOut/wrDataOut/reqReadyOut are combinational from the inputs
// given the registered grant; wrReadyIn must not depend on wrValidOut.
module fifo_write_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REQ    = 4,
  parameter int MAX_BURST  = 16,
  localparam int ID_WIDTH   = clog2_min1(NUM_REQ),
  localparam int BEAT_WIDTH = clog2_min1(MAX_BURST + 1)
) (
  input  logic                          clkIn,
  input  logic                          rstIn,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] reqDataIn,
  input  logic [NUM_REQ-1:0]            reqValidIn,
  input  logic [NUM_REQ-1:0]            reqLastIn,
  output logic [NUM_REQ-1:0]            reqReadyOut,
  output logic [DATA_WIDTH-1:0]         wrDataOut,
  output logic                          wrValidOut,
  input  logic                          wrReadyIn,
  output logic                          grantValidOut,
  output logic [ID_WIDTH-1:0]           grantIdOut
);

  logic [0:0]            stateR;
  logic [ID_WIDTH-1:0]   grantR;
  logic [ID_WIDTH-1:0]   rrPtrR;
  logic [BEAT_WIDTH-1:0] beatCountR;

  logic [ID_WIDTH-1:0]   winner;
  logic                  anyReq;
  logic                  inBurst;
  logic                  grantValid;
  logic                  grantLast;
  logic [DATA_WIDTH-1:0] grantData;
  logic                  beatAccept;
  logic                  burstDone;

  rr_priority_pick #(
    .NUM_REQ  (NUM_REQ),
    .ID_WIDTH (ID_WIDTH)
  ) u_pick (
    .requests (reqValidIn),
    .rrPtr    (rrPtrR),
    .winner   (winner),
    .anyReq   (anyReq)
  );

  assign inBurst = (stateR == ARB_BURST);

  // Select the granted requester's valid/last/data
  always_comb begin
    grantValid = 1'b0;
    grantLast  = 1'b0;
    grantData  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grantR == ID_WIDTH'(i)) begin
        grantValid = reqValidIn[i];
        grantLast  = reqLastIn[i];
        grantData  = reqDataIn[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // Drive the fifo port and route ready back to the granted requester only
  always_comb begin
    reqReadyOut = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      reqReadyOut[i] = inBurst && (grantR == ID_WIDTH'(i)) && wrReadyIn;
    end
    wrValidOut    = inBurst && grantValid;
    wrDataOut     = inBurst ? grantData : '0;
    grantValidOut = inBurst;
    grantIdOut    = inBurst ? grantR : '0;
  end

  assign beatAccept = wrValidOut && wrReadyIn;
  assign burstDone  = beatAccept &&
                      (grantLast || (beatCountR == BEAT_WIDTH'(MAX_BURST - 1)));

  // Grant FSM: arbitrate in IDLE, hold the grant through the burst
  always_ff @(posedge clkIn or posedge rstIn) begin
    if (rstIn) begin
      stateR     <= ARB_IDLE;
      grantR     <= '0;
      rrPtrR     <= '0;
      beatCountR <= '0;
    end else if (stateR == ARB_IDLE) begin
      if (anyReq) begin
        grantR     <= winner;
        beatCountR <= '0;
        stateR     <= ARB_BURST;
      end
    end else begin
      if (burstDone) begin
        stateR     <= ARB_IDLE;
        rrPtrR     <= (grantR == ID_WIDTH'(NUM_REQ - 1)) ? '0 : grantR + ID_WIDTH'(1);
        beatCountR <= '0;
      end else if (beatAccept) begin
        beatCountR <= beatCountR + BEAT_WIDTH'(1);
      end
    end
  end

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Directed bench for fifo_write_arbiter: simple per-requester producers,
// an expected-beat queue for the fifo side, and per-cycle grant traces.
module tb_fifo_write_arbiter;

  localparam int DATA_WIDTH = 32;
  localparam int NUM_REQ    = 4;
  localparam int MAX_BURST  = 16;
  localparam int ID_WIDTH   = 2;

  logic                          clkIn = 1'b0;
  logic                          rstIn;
  logic [NUM_REQ*DATA_WIDTH-1:0] reqDataIn;
  logic [NUM_REQ-1:0]            reqValidIn;
  logic [NUM_REQ-1:0]            reqLastIn;
  logic [NUM_REQ-1:0]            reqReadyOut;
  logic [DATA_WIDTH-1:0]         wrDataOut;
  logic                          wrValidOut;
  logic                          wrReadyIn;
  logic                          grantValidOut;
  logic [ID_WIDTH-1:0]           grantIdOut;

  // Clock and reset
  always #5 clkIn = ~clkIn;

  fifo_write_arbiter #(
    .DATA_WIDTH (DATA_WIDTH),
    .NUM_REQ    (NUM_REQ),
    .MAX_BURST  (MAX_BURST)
  ) dut (
    .clkIn         (clkIn),
    .rstIn         (rstIn),
    .reqDataIn     (reqDataIn),
    .reqValidIn    (reqValidIn),
    .reqLastIn     (reqLastIn),
    .reqReadyOut   (reqReadyOut),
    .wrDataOut     (wrDataOut),
    .wrValidOut    (wrValidOut),
    .wrReadyIn     (wrReadyIn),
    .grantValidOut (grantValidOut),
    .grantIdOut    (grantIdOut)
  );

  int assertCount = 0;
  int failCount   = 0;
  bit chkOn       = 1'b0;

  logic [DATA_WIDTH-1:0] expQ[$];
  int trace[$];

  // Producer model state, written only by the main initial block
  int          beatsLeft [NUM_REQ];
  int          beatIdx   [NUM_REQ];
  int          lastEvery [NUM_REQ];
  int          gapAt     [NUM_REQ];
  int          gapRem    [NUM_REQ];
  logic [31:0] dataBase  [NUM_REQ];

  task automatic checkVal(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    assertCount++;
    if (actual !== expected) begin
      failCount++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  function automatic bit inGap(input int i);
    return (beatIdx[i] == gapAt[i]) && (gapRem[i] > 0);
  endfunction

  // Driver tasks
  task automatic driveProducers();
    for (int i = 0; i < NUM_REQ; i++) begin
      reqValidIn[i] = (beatsLeft[i] > 0) && !inGap(i);
      reqLastIn[i]  = (lastEvery[i] != 0) && (((beatIdx[i] + 1) % lastEvery[i]) == 0);
      reqDataIn[i*DATA_WIDTH +: DATA_WIDTH] = dataBase[i] + 32'(beatIdx[i]);
    end
  endtask

  task automatic clearProducers();
    for (int i = 0; i < NUM_REQ; i++) begin
      beatsLeft[i] = 0;
      beatIdx[i]   = 0;
      lastEvery[i] = 0;
      gapAt[i]     = -1;
      gapRem[i]    = 0;
      dataBase[i]  = 32'(i * 256);
    end
  endtask

  // One clock: sample handshakes at negedge, advance producers after posedge
  task automatic tick();
    logic [NUM_REQ-1:0] fire;
    @(negedge clkIn);
    fire = reqValidIn & reqReadyOut;
    @(posedge clkIn);
    #1;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (fire[i]) begin
        beatIdx[i]++;
        beatsLeft[i]--;
      end else if (inGap(i)) begin
        gapRem[i]--;
      end
    end
    driveProducers();
    #1;
  endtask

  task automatic resetDut();
    rstIn = 1'b1;
    clearProducers();
    driveProducers();
    wrReadyIn = 1'b1;
    @(posedge clkIn);
    #1;
    rstIn = 1'b0;
    #1;
  endtask

  function automatic logic [63:0] grantCode(input int id);
    return (id < 0) ? 64'd0 : 64'(4 + id);
  endfunction

  task automatic runTrace(input string tag);
    for (int k = 0; k < trace.size(); k++) begin
      tick();
      checkVal($sformatf("%s grant edge%0d", tag, k + 1),
               64'({grantValidOut, grantIdOut}), grantCode(trace[k]));
    end
  endtask

  // Scoreboard: fifo-side beats against the expected queue, plus ready invariant
  always @(negedge clkIn) begin
    if (chkOn && !rstIn) begin
      checkVal("readyOneHot", 64'($onehot0(reqReadyOut)), 64'd1);
      if (wrValidOut && wrReadyIn) begin
        checkVal("beatExpected", 64'(expQ.size() > 0), 64'd1);
        if (expQ.size() > 0) checkVal("fifoData", 64'(wrDataOut), 64'(expQ.pop_front()));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rstIn     = 1'b1;
    wrReadyIn = 1'b0;
    clearProducers();
    driveProducers();
    repeat (2) @(posedge clkIn);
    #1;
    checkVal("resetGrant", 64'({grantValidOut, grantIdOut}), 64'd0);
    checkVal("resetWr", 64'({wrValidOut, wrDataOut}), 64'd0);
    checkVal("resetReady", 64'(reqReadyOut), 64'd0);
    rstIn = 1'b0;
    #1;
    chkOn = 1'b1;

    // Round-robin with all four valid, last on every 2nd beat
    resetDut();
    beatsLeft = '{4, 2, 2, 2};
    for (int i = 0; i < NUM_REQ; i++) lastEvery[i] = 2;
    for (int i = 0; i < NUM_REQ; i++) begin
      expQ.push_back(32'(i * 256));
      expQ.push_back(32'(i * 256 + 1));
    end
    expQ.push_back(32'h0000_0002);
    expQ.push_back(32'h0000_0003);
    driveProducers();
    #1;
    checkVal("rrIdleNoReady", 64'({wrValidOut, reqReadyOut}), 64'd0);
    trace = '{0, 0, -1, 1, 1, -1, 2, 2, -1, 3, 3, -1, 0, 0, -1, -1};
    runTrace("rr");
    checkVal("rrDrained", 64'(expQ.size()), 64'd0);
    checkVal("rrPtrAfterRr", 64'(dut.rrPtrR), 64'd1);

    // Burst cap: requester 2 never signals last, requester 3 waits
    resetDut();
    beatsLeft[2] = 40;
    dataBase[2]  = 32'h0000_0200;
    beatsLeft[3] = 2;
    lastEvery[3] = 2;
    dataBase[3]  = 32'h0000_0300;
    for (int b = 0; b < MAX_BURST; b++) expQ.push_back(32'h0000_0200 + 32'(b));
    expQ.push_back(32'h0000_0300);
    expQ.push_back(32'h0000_0301);
    driveProducers();
    trace = '{2, 2, 2, 2, 2, 2, 2, 2, 2, 2, 2, 2, 2, 2, 2, 2, -1, 3, 3, -1, 2};
    runTrace("cap");
    checkVal("capDrained", 64'(expQ.size()), 64'd0);
    checkVal("capBeatRestart", 64'(dut.beatCountR), 64'd0);

    // Backpressure on requester 0
    resetDut();
    beatsLeft[0] = 5;
    dataBase[0]  = 32'h0000_00A0;
    expQ.push_back(32'h0000_00A0);
    expQ.push_back(32'h0000_00A1);
    expQ.push_back(32'h0000_00A2);
    driveProducers();
    tick();
    checkVal("bpGrant", 64'({grantValidOut, grantIdOut}), grantCode(0));
    begin
      logic        readyPat [5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
      logic [31:0] dataPat  [5] = '{32'hA0, 32'hA1, 32'hA1, 32'hA1, 32'hA2};
      for (int p = 0; p < 5; p++) begin
        wrReadyIn = readyPat[p];
        #1;
        checkVal($sformatf("bpReady%0d", p), 64'(reqReadyOut), 64'(readyPat[p]));
        checkVal($sformatf("bpData%0d", p), 64'(wrDataOut), 64'(dataPat[p]));
        tick();
      end
    end
    wrReadyIn = 1'b0;
    #1;
    checkVal("bpBeatCount", 64'(dut.beatCountR), 64'd3);
    checkVal("bpHold", 64'({grantValidOut, grantIdOut}), grantCode(0));
    checkVal("bpDrained", 64'(expQ.size()), 64'd0);

    // Valid gap on requester 1 while requester 0 waits
    resetDut();
    beatsLeft[1] = 4;
    lastEvery[1] = 4;
    gapAt[1]     = 2;
    gapRem[1]    = 5;
    for (int b = 0; b < 4; b++) expQ.push_back(32'h0000_0100 + 32'(b));
    expQ.push_back(32'h0000_0000);
    driveProducers();
    trace = '{1, 1, 1, 1, 1, 1, 1, 1, 1, -1, 0, -1};
    for (int k = 0; k < trace.size(); k++) begin
      tick();
      if (k == 0) begin
        beatsLeft[0] = 1;
        lastEvery[0] = 1;
        driveProducers();
        #1;
      end
      checkVal($sformatf("gap grant edge%0d", k + 1),
               64'({grantValidOut, grantIdOut}), grantCode(trace[k]));
      if (k >= 2 && k <= 6) checkVal($sformatf("gapNoValid edge%0d", k + 1), 64'(wrValidOut), 64'd0);
      if (k == 9) checkVal("gapPtr", 64'(dut.rrPtrR), 64'd2);
    end
    checkVal("gapPtrEnd", 64'(dut.rrPtrR), 64'd1);
    checkVal("gapDrained", 64'(expQ.size()), 64'd0);

    // Sparse wrap: requester 3 alone, then requester 0
    resetDut();
    beatsLeft[3] = 1;
    lastEvery[3] = 1;
    dataBase[3]  = 32'h0000_0300;
    expQ.push_back(32'h0000_0300);
    expQ.push_back(32'h0000_0000);
    driveProducers();
    trace = '{3, -1, 0, -1};
    for (int k = 0; k < trace.size(); k++) begin
      tick();
      if (k == 1) begin
        checkVal("wrapPtr", 64'(dut.rrPtrR), 64'd0);
        beatsLeft[0] = 1;
        lastEvery[0] = 1;
        driveProducers();
        #1;
      end
      checkVal($sformatf("wrap grant edge%0d", k + 1),
               64'({grantValidOut, grantIdOut}), grantCode(trace[k]));
    end
    checkVal("wrapDrained", 64'(expQ.size()), 64'd0);

    // Reset mid-burst: requester 1 has 3 beats accepted, then async reset
    resetDut();
    beatsLeft[1] = 10;
    dataBase[1]  = 32'h0000_0110;
    for (int b = 0; b < 3; b++) expQ.push_back(32'h0000_0110 + 32'(b));
    driveProducers();
    repeat (4) tick();
    checkVal("rstMidBeats", 64'(dut.beatCountR), 64'd3);
    checkVal("rstMidGrant", 64'({grantValidOut, grantIdOut}), grantCode(1));
    #1;
    rstIn = 1'b1;
    #1;
    checkVal("rstAsyncGrant", 64'({grantValidOut, grantIdOut}), 64'd0);
    checkVal("rstAsyncWr", 64'({wrValidOut, wrDataOut}), 64'd0);
    checkVal("rstAsyncReady", 64'(reqReadyOut), 64'd0);
    clearProducers();
    driveProducers();
    rstIn = 1'b0;
    checkVal("rstPtr", 64'(dut.rrPtrR), 64'd0);
    checkVal("rstDrained", 64'(expQ.size()), 64'd0);
    for (int i = 0; i < NUM_REQ; i++) begin
      beatsLeft[i] = 1;
      lastEvery[i] = 1;
      dataBase[i]  = 32'h0000_0400 + 32'(i * 16);
      expQ.push_back(32'h0000_0400 + 32'(i * 16));
    end
    driveProducers();
    trace = '{0, -1, 1, -1, 2, -1, 3, -1};
    runTrace("postRst");

    checkVal("finalDrain", 64'(expQ.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
